// File: rtl/bin2bcd_conv.sv
// bin2bcd_conv: sequential double-dabble binary-to-BCD converter, one bit per clock,
// with a start/ready/done-tick handshake.
module bin2bcd_conv #(
    parameter int DATA_W = 20,
    parameter int DIGITS = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [DATA_W-1:0]     i_bin,
    output logic                  o_ready,
    output logic                  o_done_tick,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_overflow
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(DATA_W);

    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_bin;
    logic [BW-1:0]     r_bcd;
    logic              r_ovf;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     w_adj;
    logic [BW-1:0]     w_shift;
    logic              w_out;

    for (genvar k = 0; k < DIGITS; k++) begin : g_adj
        assign w_adj[4*k+:4] = (r_bcd[4*k+:4] >= 4'd5) ? r_bcd[4*k+:4] + 4'd3 : r_bcd[4*k+:4];
    end

    // w_out carries weight 10^DIGITS, so dropping it leaves the value mod 10^DIGITS
    assign {w_out, w_shift} = {w_adj, r_bin[DATA_W-1]};
    assign o_ready = (r_state == IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
            o_bcd       <= '0;
            o_overflow  <= 1'b0;
            o_done_tick <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_done_tick <= 1'b0;
                    if (i_start) begin
                        r_bin   <= i_bin;
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= CNT_INIT;
                        r_state <= OP;
                    end
                end
                OP: begin
                    r_bin <= {r_bin[DATA_W-2:0], 1'b0};
                    r_bcd <= w_shift;
                    r_ovf <= r_ovf | w_out;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        o_bcd       <= w_shift;
                        o_overflow  <= r_ovf | w_out;
                        o_done_tick <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    o_done_tick <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    o_done_tick <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end
endmodule
